// File: rtl/gray_pkg.sv
// Shared definitions for the Gray position decode path: FSM state encoding and
// a width-generic Gray-to-binary conversion mirroring the binary-to-Gray encoder.
package gray_pkg;

    localparam int unsigned GRAY_MAXW = 32;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Zero-extended inputs decode identically, so one max-width function serves any W.
    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
        logic [GRAY_MAXW-1:0] b;
        b = '0;
        b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
        for (int unsigned k = 1; k < GRAY_MAXW; k++) begin
            b[GRAY_MAXW-1-k] = b[GRAY_MAXW-k] ^ g[GRAY_MAXW-1-k];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational W-bit Gray-to-binary decoder.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = W'(gray2bin(GRAY_MAXW'(gray)));
    end

endmodule

// File: rtl/gray_position_decoder.sv
// Synchronizes an asynchronous Gray position bus, decodes it, classifies each change
// as a step up/down or an illegal jump, and accumulates a wide signed position.
module gray_position_decoder
    import gray_pkg::*;
#(
    parameter int unsigned W    = 4,
    parameter int unsigned POSW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           g_in,
    input  logic                   en,
    input  logic                   err_clr,
    output logic [W-1:0]           bin_out,
    output logic                   valid,
    output logic                   step,
    output logic                   dir,
    output logic signed [POSW-1:0] pos,
    output logic                   err
);

    logic [W-1:0]           s1, s2, d, delta;
    state_t                 state, state_next;
    logic                   step_up, step_dn, jump;
    logic [W-1:0]           bin_next;
    logic                   valid_next, step_next, dir_next, err_next;
    logic signed [POSW-1:0] pos_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= g_in;
            s2 <= s1;
        end
    end

    gray_to_bin #(.W(W)) u_dec (
        .gray (s2),
        .bin  (d)
    );

    // Modular difference makes the 2^W-1 <-> 0 wrap look like an ordinary +/-1.
    always_comb begin
        delta   = d - bin_out;
        step_up = (delta == W'(1));
        step_dn = (delta == '1);
        jump    = (delta != '0) && !step_up && !step_dn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = INIT;
        end else begin
            case (state)
                INIT:    state_next = TRACK;
                TRACK:   if (jump) state_next = FAULT;
                FAULT:   if (err_clr) state_next = INIT;
                default: state_next = INIT;
            endcase
        end
    end

    always_comb begin
        bin_next   = bin_out;
        valid_next = valid;
        step_next  = 1'b0;
        dir_next   = dir;
        pos_next   = pos;
        err_next   = err;
        if (!en) begin
            valid_next = 1'b0;
        end else begin
            bin_next = d;
            case (state)
                INIT: valid_next = 1'b1;
                TRACK: begin
                    if (step_up) begin
                        step_next = 1'b1;
                        dir_next  = 1'b1;
                        pos_next  = pos + POSW'(1);
                    end else if (step_dn) begin
                        step_next = 1'b1;
                        dir_next  = 1'b0;
                        pos_next  = pos - POSW'(1);
                    end else if (jump) begin
                        err_next = 1'b1;
                    end
                end
                FAULT: if (err_clr) err_next = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out <= '0;
            valid   <= 1'b0;
            step    <= 1'b0;
            dir     <= 1'b0;
            pos     <= '0;
            err     <= 1'b0;
        end else begin
            bin_out <= bin_next;
            valid   <= valid_next;
            step    <= step_next;
            dir     <= dir_next;
            pos     <= pos_next;
            err     <= err_next;
        end
    end

endmodule

// File: tb/tb_gray_position_decoder.sv
// Directed self-checking bench for gray_position_decoder (W=4, POSW=16).
module tb_gray_position_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  g_in = '0;
    logic        en = 1'b0;
    logic        err_clr = 1'b0;
    logic [3:0]  bin_out;
    logic        valid, step, dir, err;
    logic [15:0] pos;

    int nvec = 0;
    int nerr = 0;

    gray_position_decoder #(.W(4), .POSW(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g_in    (g_in),
        .en      (en),
        .err_clr (err_clr),
        .bin_out (bin_out),
        .valid   (valid),
        .step    (step),
        .dir     (dir),
        .pos     (pos),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Code enters s1, s2, then outputs: three edges until it is reflected.
    task automatic settle(input logic [3:0] g);
        g_in = g;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; g_in = 4'b0000;
        repeat (2) tick();
        nvec++; if ({bin_out, valid, step, dir, err} !== 8'h00) begin nerr++; $display("FAIL reset_flags: got %b expected 00000000", {bin_out, valid, step, dir, err}); end
        nvec++; if (pos !== 16'h0000) begin nerr++; $display("FAIL reset_pos: got %h expected 0000", pos); end
        rst_n = 1'b1; en = 1'b1;
        repeat (3) tick();
        nvec++; if (valid !== 1'b1) begin nerr++; $display("FAIL init_valid: got %b expected 1", valid); end
        nvec++; if (bin_out !== 4'd0) begin nerr++; $display("FAIL init_bin: got %0d expected 0", bin_out); end
        nvec++; if (step !== 1'b0 || err !== 1'b0) begin nerr++; $display("FAIL init_step_err: got %b%b expected 00", step, err); end
        nvec++; if (pos !== 16'h0000) begin nerr++; $display("FAIL init_pos: got %h expected 0000", pos); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] codes [4];
        int steps;
        codes = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
        steps = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) g_in = codes[i];
            tick();
            if (step === 1'b1) steps++;
            if (i >= 2) begin
                nvec++; if (bin_out !== 4'(i - 1)) begin nerr++; $display("FAIL walk_bin[%0d]: got %0d expected %0d", i, bin_out, i - 1); end
            end
        end
        tick();
        nvec++; if (steps != 4) begin nerr++; $display("FAIL walk_steps: got %0d expected 4", steps); end
        nvec++; if (dir !== 1'b1) begin nerr++; $display("FAIL walk_dir: got %b expected 1", dir); end
        nvec++; if (pos !== 16'd4) begin nerr++; $display("FAIL walk_pos: got %h expected 0004", pos); end
        nvec++; if (step !== 1'b0) begin nerr++; $display("FAIL walk_step_idle: got %b expected 0", step); end
    endtask

    task automatic test_wrap();
        en = 1'b0;
        settle(4'b1000);
        en = 1'b1;
        tick();
        nvec++; if (bin_out !== 4'd15 || step !== 1'b0 || pos !== 16'd4) begin nerr++; $display("FAIL wrap_reref: got bin=%0d step=%b pos=%h expected bin=15 step=0 pos=0004", bin_out, step, pos); end
        settle(4'b0000);
        nvec++; if (step !== 1'b1 || dir !== 1'b1 || pos !== 16'd5 || bin_out !== 4'd0) begin nerr++; $display("FAIL wrap_up: got step=%b dir=%b pos=%h bin=%0d expected 1 1 0005 0", step, dir, pos, bin_out); end
        settle(4'b1000);
        nvec++; if (step !== 1'b1 || dir !== 1'b0 || pos !== 16'd4 || bin_out !== 4'd15) begin nerr++; $display("FAIL wrap_down: got step=%b dir=%b pos=%h bin=%0d expected 1 0 0004 15", step, dir, pos, bin_out); end
        rst_n = 1'b0; g_in = 4'b0000;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        settle(4'b1000); settle(4'b1001); settle(4'b1011); settle(4'b1010); settle(4'b1110);
        nvec++; if (pos !== 16'hFFFB) begin nerr++; $display("FAIL down5_pos: got %h expected fffb", pos); end
        nvec++; if (dir !== 1'b0 || bin_out !== 4'd11) begin nerr++; $display("FAIL down5_dir_bin: got dir=%b bin=%0d expected 0 11", dir, bin_out); end
    endtask

    task automatic test_illegal();
        en = 1'b0;
        settle(4'b0000);
        en = 1'b1;
        tick();
        settle(4'b0011);
        nvec++; if (err !== 1'b1 || step !== 1'b0) begin nerr++; $display("FAIL jump_err: got err=%b step=%b expected 1 0", err, step); end
        nvec++; if (pos !== 16'hFFFB || bin_out !== 4'd2) begin nerr++; $display("FAIL jump_pos_bin: got pos=%h bin=%0d expected fffb 2", pos, bin_out); end
        settle(4'b0010);
        nvec++; if (step !== 1'b0 || pos !== 16'hFFFB || bin_out !== 4'd3) begin nerr++; $display("FAIL fault_frozen: got step=%b pos=%h bin=%0d expected 0 fffb 3", step, pos, bin_out); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL err_clr: got %b expected 0", err); end
        tick();
        nvec++; if (step !== 1'b0 || pos !== 16'hFFFB) begin nerr++; $display("FAIL reref_nostep: got step=%b pos=%h expected 0 fffb", step, pos); end
        settle(4'b0110);
        nvec++; if (step !== 1'b1 || dir !== 1'b1 || pos !== 16'hFFFC || bin_out !== 4'd4) begin nerr++; $display("FAIL after_clr_step: got step=%b dir=%b pos=%h bin=%0d expected 1 1 fffc 4", step, dir, pos, bin_out); end
    endtask

    task automatic test_clr_collision();
        g_in = 4'b0101;
        repeat (2) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL collision_err: got %b expected 1", err); end
        settle(4'b0111);
        nvec++; if (step !== 1'b0 || pos !== 16'hFFFC || bin_out !== 4'd5) begin nerr++; $display("FAIL collision_fault: got step=%b pos=%h bin=%0d expected 0 fffc 5", step, pos, bin_out); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        tick();
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL collision_clr: got %b expected 0", err); end
    endtask

    task automatic test_enable();
        int steps;
        steps = 0;
        en = 1'b0;
        g_in = 4'b1100; tick(); if (step === 1'b1) steps++;
        g_in = 4'b1101; tick(); if (step === 1'b1) steps++;
        g_in = 4'b1111; tick(); if (step === 1'b1) steps++;
        repeat (2) begin tick(); if (step === 1'b1) steps++; end
        nvec++; if (steps != 0 || valid !== 1'b0) begin nerr++; $display("FAIL en_off: got steps=%0d valid=%b expected 0 0", steps, valid); end
        nvec++; if (bin_out !== 4'd5 || pos !== 16'hFFFC || err !== 1'b0) begin nerr++; $display("FAIL en_hold: got bin=%0d pos=%h err=%b expected 5 fffc 0", bin_out, pos, err); end
        en = 1'b1;
        tick();
        nvec++; if (bin_out !== 4'd10 || valid !== 1'b1 || step !== 1'b0 || err !== 1'b0 || pos !== 16'hFFFC) begin nerr++; $display("FAIL en_reref: got bin=%0d valid=%b step=%b err=%b pos=%h expected 10 1 0 0 fffc", bin_out, valid, step, err, pos); end
    endtask

    task automatic test_reset_mid();
        settle(4'b1110);
        nvec++; if (step !== 1'b1 || pos !== 16'hFFFD) begin nerr++; $display("FAIL premid_step: got step=%b pos=%h expected 1 fffd", step, pos); end
        g_in = 4'b1010;
        tick();
        #2 rst_n = 1'b0;
        #1;
        nvec++; if ({bin_out, valid, step, dir, err} !== 8'h00 || pos !== 16'h0000) begin nerr++; $display("FAIL async_reset: got flags=%b pos=%h expected 00000000 0000", {bin_out, valid, step, dir, err}, pos); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_illegal();
        test_clr_collision();
        test_enable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
